// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory bus responder: FSM state encoding and default bus widths.
package mem_bus_responder_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Index width for a store of 'depth' words; a single-word store still needs one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bus_resp_ram.sv
// DEPTH x DATA_W single-port store with one write enable and a registered read port.
module bus_resp_ram
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Write accesses return zero so a write ack carries no stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: one outstanding request, fixed wait states, valid/ready on both sides.
// Optional address range check enabled by defining BUS_RESP_ERR_EN.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_busy
);

    localparam int unsigned IDX_W = idx_width(DEPTH);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [31:0]       addr_ext;
    logic [IDX_W-1:0]  idx;
    logic              access;
    logic              addr_err;
    logic [DATA_W-1:0] ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every accept passes through WAIT with the counter preloaded to WAIT_CYC, so the
    // store is accessed and the response raised WAIT_CYC+1 edges after the accept edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_CYC);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == ST_IDLE && i_req_valid) begin
            we_q    <= i_req_we;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
        end
    end

    assign access      = (state_q == ST_WAIT) && (cnt_q == '0);
    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_busy      = (state_q != ST_IDLE);

    always_comb begin
        addr_ext = 32'(addr_q);
        idx      = IDX_W'(addr_ext % DEPTH);
    end

`ifdef BUS_RESP_ERR_EN
    logic err_q;

    assign addr_err = (addr_ext >= DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (access) begin
            err_q <= addr_err;
        end
    end

    assign o_rsp_err   = err_q;
    assign o_rsp_rdata = err_q ? '0 : ram_rdata;
`else
    assign addr_err    = 1'b0;
    assign o_rsp_err   = 1'b0;
    assign o_rsp_rdata = ram_rdata;
`endif

    bus_resp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (access),
        .we    (we_q & ~addr_err),
        .addr  (idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench: three responder instances (WAIT_CYC=2, WAIT_CYC=0, DEPTH=128).
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_we    [3];
    logic [7:0]  req_addr  [3];
    logic [15:0] req_wdata [3];
    logic        rsp_ready [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic [15:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_bus_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(2)) u_w2 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_we(req_we[0]),
        .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
        .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]), .o_busy(busy[0]));

    mem_bus_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(0)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_we(req_we[1]),
        .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
        .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]), .o_busy(busy[1]));

    mem_bus_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_CYC(2)) u_d128 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]), .i_req_we(req_we[2]),
        .i_req_addr(req_addr[2]), .i_req_wdata(req_wdata[2]),
        .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]),
        .o_rsp_rdata(rsp_rdata[2]), .o_rsp_err(rsp_err[2]), .o_busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request, then scramble the request fields after the accept edge and
    // count edges until the response appears.
    task automatic issue(input int d, input logic we, input logic [7:0] a, input logic [15:0] wd,
                         input logic early_rdy, input string tag, input int exp_lat);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        n = 0;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready"}, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = ~a;
        req_wdata[d] = ~wd;
        rsp_ready[d] = early_rdy;
        chk({tag, " busy"}, {30'd0, busy[d], req_ready[d]}, 32'd2);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rsp_valid[d] && n < 40);
        chk({tag, " latency"}, n, exp_lat);
    endtask

    task automatic take(input int d, input string tag);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " idle"}, {29'd0, rsp_valid[d], req_ready[d], busy[d]}, 32'd2);
        rsp_ready[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset ready %0d", d), 32'(req_ready[d]), 32'd1);
            chk($sformatf("reset valid %0d", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("reset rdata %0d", d), 32'(rsp_rdata[d]), 32'd0);
            chk($sformatf("reset busy %0d", d), 32'(busy[d]), 32'd0);
            chk($sformatf("reset err %0d", d), 32'(rsp_err[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // WAIT_CYC=2 write then read, 3-edge latency
        issue(0, 1'b1, 8'h10, 16'hBEEF, 1'b1, "w2 wr", 3);
        chk("w2 wr rdata", 32'(rsp_rdata[0]), 32'h0);
        chk("w2 wr err", 32'(rsp_err[0]), 32'h0);
        take(0, "w2 wr");
        issue(0, 1'b0, 8'h10, 16'h0000, 1'b0, "w2 rd", 3);
        chk("w2 rd rdata", 32'(rsp_rdata[0]), 32'hBEEF);
        take(0, "w2 rd");

        // Backpressure with a competing request held during RESP
        issue(0, 1'b0, 8'h10, 16'h0000, 1'b0, "bp rd", 3);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 8'h10;
        req_wdata[0] = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold %0d", i),
                {14'd0, rsp_valid[0], req_ready[0], rsp_rdata[0]}, {16'h2, 16'hBEEF});
        end
        take(0, "bp");
        req_valid[0] = 1'b0;
        issue(0, 1'b0, 8'h10, 16'h0000, 1'b0, "bp rd2", 3);
        chk("bp rd2 rdata", 32'(rsp_rdata[0]), 32'hBEEF);
        take(0, "bp rd2");

        // WAIT_CYC=0, 1-edge latency
        issue(1, 1'b1, 8'h05, 16'h1234, 1'b0, "w0 wr", 1);
        chk("w0 wr rdata", 32'(rsp_rdata[1]), 32'h0);
        take(1, "w0 wr");
        issue(1, 1'b0, 8'h05, 16'h0000, 1'b0, "w0 rd", 1);
        chk("w0 rd rdata", 32'(rsp_rdata[1]), 32'h1234);
        take(1, "w0 rd");

        // Reset during WAIT drops the pending write
        issue(0, 1'b1, 8'h20, 16'h5555, 1'b1, "rs wr1", 3);
        take(0, "rs wr1");
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 8'h20;
        req_wdata[0] = 16'hAAAA;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("rs in wait", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rs abort", {14'd0, req_ready[0], rsp_valid[0], busy[0], rsp_rdata[0]}, {16'h4, 16'h0});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen = seen | rsp_valid[0];
        end
        chk("rs no rsp", 32'(seen), 32'd0);
        issue(0, 1'b0, 8'h20, 16'h0000, 1'b0, "rs rd", 3);
        chk("rs rd rdata", 32'(rsp_rdata[0]), 32'h5555);
        take(0, "rs rd");

        // DEPTH=128: out-of-range address handling
`ifdef BUS_RESP_ERR_EN
        issue(2, 1'b1, 8'h10, 16'h1111, 1'b0, "d128 wr ok", 3);
        chk("d128 wr ok err", 32'(rsp_err[2]), 32'd0);
        take(2, "d128 wr ok");
        issue(2, 1'b1, 8'h90, 16'h0F0F, 1'b0, "d128 wr bad", 3);
        chk("d128 wr bad err", {15'd0, rsp_err[2], rsp_rdata[2]}, {16'h1, 16'h0});
        take(2, "d128 wr bad");
        issue(2, 1'b0, 8'h10, 16'h0000, 1'b0, "d128 rd ok", 3);
        chk("d128 rd ok", {15'd0, rsp_err[2], rsp_rdata[2]}, {16'h0, 16'h1111});
        take(2, "d128 rd ok");
        issue(2, 1'b0, 8'h90, 16'h0000, 1'b0, "d128 rd bad", 3);
        chk("d128 rd bad", {15'd0, rsp_err[2], rsp_rdata[2]}, {16'h1, 16'h0});
        take(2, "d128 rd bad");
`else
        issue(2, 1'b1, 8'h90, 16'h0F0F, 1'b0, "d128 wr", 3);
        chk("d128 wr", {15'd0, rsp_err[2], rsp_rdata[2]}, {16'h0, 16'h0});
        take(2, "d128 wr");
        issue(2, 1'b0, 8'h10, 16'h0000, 1'b0, "d128 rd", 3);
        chk("d128 rd", {15'd0, rsp_err[2], rsp_rdata[2]}, {16'h0, 16'h0F0F});
        take(2, "d128 rd");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
